// File: rtl/wts_ram_arbiter.sv
// rtl/wts_ram_arbiter.sv - CPU / channel-fetch arbiter for the wave-table SRAM port
module wts_ram_arbiter #(
    parameter int         RAM_WORDS    = 384,
    parameter logic [7:0] CPU_OOR_DATA = 8'hFF,
    parameter logic [7:0] CH_OOR_DATA  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [8:0] cpu_a,
    input  logic [7:0] cpu_d,
    output logic       cpu_ack,
    output logic [7:0] cpu_q,
    output logic       cpu_q_valid,
    input  logic       ch_req,
    input  logic [3:0] ch_num,
    input  logic [4:0] ch_ptr,
    output logic       ch_ack,
    output logic [7:0] ch_q,
    output logic [3:0] ch_q_num,
    output logic       ch_q_valid,
    output logic       sram_we,
    output logic [8:0] sram_a,
    output logic [7:0] sram_d,
    input  logic [7:0] sram_q
);

    typedef enum logic {LAST_CH, LAST_CPU} arb_state_e;

    arb_state_e state_q, state_d;

    logic       grant_cpu, grant_ch, grant_any;
    logic [8:0] ch_addr, acc_addr;
    logic       cpu_oor, ch_oor, acc_oor, acc_we;

    logic       sram_we_q, sram_we_d;
    logic [8:0] sram_a_q, sram_a_d;
    logic [7:0] sram_d_q, sram_d_d;

    // Read tag for stage 1 (RAM address cycle) and stage 2 (RAM data cycle)
    logic       s1_vld_q, s1_vld_d, s1_cpu_q, s1_cpu_d, s1_oor_q, s1_oor_d;
    logic [3:0] s1_num_q, s1_num_d;
    logic       s2_vld_q, s2_cpu_q, s2_oor_q;
    logic [3:0] s2_num_q;

    logic       cpu_q_valid_q, ch_q_valid_q;
    logic [7:0] cpu_q_q, ch_q_q;
    logic [3:0] ch_q_num_q;

    assign ch_addr = {ch_num, ch_ptr};
    assign cpu_oor = 32'(cpu_a) >= RAM_WORDS;
    assign ch_oor  = 32'(ch_addr) >= RAM_WORDS;

    // Acks are combinational, so they are held off explicitly while reset is asserted
    always_comb begin
        grant_cpu = 1'b0;
        grant_ch  = 1'b0;
        state_d   = state_q;
        if (!reset) begin
            if (cpu_req && (!ch_req || state_q == LAST_CH)) begin
                grant_cpu = 1'b1;
                state_d   = LAST_CPU;
            end else if (ch_req) begin
                grant_ch = 1'b1;
                state_d  = LAST_CH;
            end
        end
    end

    assign grant_any = grant_cpu | grant_ch;
    assign acc_addr  = grant_cpu ? cpu_a : ch_addr;
    assign acc_oor   = grant_cpu ? cpu_oor : ch_oor;
    assign acc_we    = grant_cpu & cpu_we;

    always_comb begin
        sram_we_d = grant_any & acc_we & ~acc_oor;
        sram_a_d  = (grant_any && !acc_oor) ? acc_addr : 9'd0;
        sram_d_d  = (grant_any && acc_we && !acc_oor) ? cpu_d : 8'd0;
        s1_vld_d  = grant_any & ~acc_we;
        s1_cpu_d  = grant_cpu;
        s1_oor_d  = acc_oor;
        s1_num_d  = grant_ch ? ch_num : 4'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= LAST_CH;
            sram_we_q <= 1'b0;
            sram_a_q  <= 9'd0;
            sram_d_q  <= 8'd0;
            s1_vld_q  <= 1'b0;
            s1_cpu_q  <= 1'b0;
            s1_oor_q  <= 1'b0;
            s1_num_q  <= 4'd0;
            s2_vld_q  <= 1'b0;
            s2_cpu_q  <= 1'b0;
            s2_oor_q  <= 1'b0;
            s2_num_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            sram_we_q <= sram_we_d;
            sram_a_q  <= sram_a_d;
            sram_d_q  <= sram_d_d;
            s1_vld_q  <= s1_vld_d;
            s1_cpu_q  <= s1_cpu_d;
            s1_oor_q  <= s1_oor_d;
            s1_num_q  <= s1_num_d;
            s2_vld_q  <= s1_vld_q;
            s2_cpu_q  <= s1_cpu_q;
            s2_oor_q  <= s1_oor_q;
            s2_num_q  <= s1_num_q;
        end
    end

    // sram_q belongs to the stage-2 access; OOR accesses substitute fixed data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_q_valid_q <= 1'b0;
            cpu_q_q       <= 8'd0;
            ch_q_valid_q  <= 1'b0;
            ch_q_q        <= 8'd0;
            ch_q_num_q    <= 4'd0;
        end else begin
            cpu_q_valid_q <= s2_vld_q & s2_cpu_q;
            ch_q_valid_q  <= s2_vld_q & ~s2_cpu_q;
            if (s2_vld_q && s2_cpu_q) begin
                cpu_q_q <= s2_oor_q ? CPU_OOR_DATA : sram_q;
            end
            if (s2_vld_q && !s2_cpu_q) begin
                ch_q_q     <= s2_oor_q ? CH_OOR_DATA : sram_q;
                ch_q_num_q <= s2_num_q;
            end
        end
    end

    assign cpu_ack     = grant_cpu;
    assign ch_ack      = grant_ch;
    assign sram_we     = sram_we_q;
    assign sram_a      = sram_a_q;
    assign sram_d      = sram_d_q;
    assign cpu_q       = cpu_q_q;
    assign cpu_q_valid = cpu_q_valid_q;
    assign ch_q        = ch_q_q;
    assign ch_q_num    = ch_q_num_q;
    assign ch_q_valid  = ch_q_valid_q;

endmodule

// File: tb/tb_wts_ram_arbiter.sv
// tb/tb_wts_ram_arbiter.sv - directed bench for wts_ram_arbiter with a registered-read RAM model
module tb_wts_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we;
    logic [8:0] cpu_a;
    logic [7:0] cpu_d;
    logic       cpu_ack, cpu_q_valid;
    logic [7:0] cpu_q;
    logic       ch_req;
    logic [3:0] ch_num;
    logic [4:0] ch_ptr;
    logic       ch_ack, ch_q_valid;
    logic [7:0] ch_q;
    logic [3:0] ch_q_num;
    logic       sram_we;
    logic [8:0] sram_a;
    logic [7:0] sram_d;
    logic [7:0] sram_q;
    logic       ram_init;
    logic [7:0] mem [0:511];

    int pass_cnt = 0;
    int total_cnt = 0;

    wts_ram_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_ack(cpu_ack), .cpu_q(cpu_q), .cpu_q_valid(cpu_q_valid),
        .ch_req(ch_req), .ch_num(ch_num), .ch_ptr(ch_ptr),
        .ch_ack(ch_ack), .ch_q(ch_q), .ch_q_num(ch_q_num), .ch_q_valid(ch_q_valid),
        .sram_we(sram_we), .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
    );

    always #5 clk = ~clk;

    // RAM model: default content is addr ^ 0xA5, one-cycle registered read
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'(i) ^ 8'hA5;
        end else if (sram_we) begin
            mem[sram_a] <= sram_d;
        end
        sram_q <= mem[sram_a];
    end

    task test_reset;
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 9'h010; cpu_d = 8'hEE;
        ch_req = 1'b1; ch_num = 4'd3; ch_ptr = 5'd4;
        @(negedge clk); #1;
        if (cpu_ack !== 1'b0) $display("FAIL rst_cpu_ack got %b exp 0", cpu_ack); else pass_cnt++;
        total_cnt++;
        if (ch_ack !== 1'b0) $display("FAIL rst_ch_ack got %b exp 0", ch_ack); else pass_cnt++;
        total_cnt++;
        if ({sram_we, sram_a, sram_d} !== 18'd0)
            $display("FAIL rst_sram got %b/%h/%h exp 0/0/0", sram_we, sram_a, sram_d);
        else pass_cnt++;
        total_cnt++;
        if ({cpu_q_valid, cpu_q, ch_q_valid, ch_q, ch_q_num} !== 22'd0)
            $display("FAIL rst_q got %b/%h/%b/%h/%h exp all 0", cpu_q_valid, cpu_q, ch_q_valid, ch_q, ch_q_num);
        else pass_cnt++;
        total_cnt++;
        cpu_req = 1'b0; ch_req = 1'b0; ram_init = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task test_cpu_write_read;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 9'h123; cpu_d = 8'h5A; #1;
        if (cpu_ack !== 1'b1) $display("FAIL wr_ack got %b exp 1", cpu_ack); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if ({sram_we, sram_a, sram_d} !== {1'b1, 9'h123, 8'h5A})
            $display("FAIL wr_sram got %b/%h/%h exp 1/123/5a", sram_we, sram_a, sram_d);
        else pass_cnt++;
        total_cnt++;
        cpu_we = 1'b0; #1;
        if (cpu_ack !== 1'b1) $display("FAIL rd_ack got %b exp 1", cpu_ack); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if ({sram_we, sram_a} !== {1'b0, 9'h123})
            $display("FAIL rd_sram got %b/%h exp 0/123", sram_we, sram_a);
        else pass_cnt++;
        total_cnt++;
        cpu_req = 1'b0;
        @(negedge clk);
        if (cpu_q_valid !== 1'b0) $display("FAIL wr_no_qvalid got %b exp 0", cpu_q_valid); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if ({cpu_q_valid, cpu_q} !== {1'b1, 8'h5A})
            $display("FAIL rd_data got %b/%h exp 1/5a", cpu_q_valid, cpu_q);
        else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if ({cpu_q_valid, cpu_q} !== {1'b0, 8'h5A})
            $display("FAIL rd_hold got %b/%h exp 0/5a", cpu_q_valid, cpu_q);
        else pass_cnt++;
        total_cnt++;
    endtask

    task test_ch_fetch;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 9'h17F; cpu_d = 8'h77; #1;
        if (cpu_ack !== 1'b1) $display("FAIL pre_ack got %b exp 1", cpu_ack); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        cpu_req = 1'b0; ch_req = 1'b1; ch_num = 4'd11; ch_ptr = 5'd31; #1;
        if ({ch_ack, cpu_ack} !== 2'b10) $display("FAIL ch_ack got %b%b exp 10", ch_ack, cpu_ack); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if ({sram_we, sram_a} !== {1'b0, 9'h17F})
            $display("FAIL ch_sram got %b/%h exp 0/17f", sram_we, sram_a);
        else pass_cnt++;
        total_cnt++;
        ch_req = 1'b0;
        @(negedge clk);
        if (ch_q_valid !== 1'b0) $display("FAIL ch_early got %b exp 0", ch_q_valid); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if ({ch_q_valid, ch_q, ch_q_num} !== {1'b1, 8'h77, 4'd11})
            $display("FAIL ch_data got %b/%h/%0d exp 1/77/11", ch_q_valid, ch_q, ch_q_num);
        else pass_cnt++;
        total_cnt++;
    endtask

    task test_both;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 9'h123;
        ch_req = 1'b1; ch_num = 4'd0; ch_ptr = 5'd5; #1;
        if ({cpu_ack, ch_ack} !== 2'b10) $display("FAIL both_n got %b%b exp 10", cpu_ack, ch_ack); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if (sram_a !== 9'h123) $display("FAIL both_sram_cpu got %h exp 123", sram_a); else pass_cnt++;
        total_cnt++;
        cpu_req = 1'b0; #1;
        if ({cpu_ack, ch_ack} !== 2'b01) $display("FAIL both_n1 got %b%b exp 01", cpu_ack, ch_ack); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if (sram_a !== 9'h005) $display("FAIL both_sram_ch got %h exp 005", sram_a); else pass_cnt++;
        total_cnt++;
        ch_req = 1'b0;
        @(negedge clk);
        if ({cpu_q_valid, cpu_q, ch_q_valid} !== {1'b1, 8'h5A, 1'b0})
            $display("FAIL both_cpu_q got %b/%h/%b exp 1/5a/0", cpu_q_valid, cpu_q, ch_q_valid);
        else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if ({ch_q_valid, ch_q, ch_q_num, cpu_q_valid} !== {1'b1, 8'hA0, 4'd0, 1'b0})
            $display("FAIL both_ch_q got %b/%h/%0d/%b exp 1/a0/0/0", ch_q_valid, ch_q, ch_q_num, cpu_q_valid);
        else pass_cnt++;
        total_cnt++;
    endtask

    task test_back_to_back;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 9'h010; cpu_d = 8'h33; #1;
        if (cpu_ack !== 1'b1) $display("FAIL b2b_ack0 got %b exp 1", cpu_ack); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if ({sram_we, sram_a, sram_d} !== {1'b1, 9'h010, 8'h33})
            $display("FAIL b2b_sram0 got %b/%h/%h exp 1/010/33", sram_we, sram_a, sram_d);
        else pass_cnt++;
        total_cnt++;
        cpu_a = 9'h011; cpu_d = 8'h44; ch_req = 1'b1; ch_num = 4'd1; ch_ptr = 5'd2; #1;
        if ({cpu_ack, ch_ack} !== 2'b01) $display("FAIL b2b_lastcpu got %b%b exp 01", cpu_ack, ch_ack); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if ({sram_we, sram_a} !== {1'b0, 9'h022})
            $display("FAIL b2b_sram1 got %b/%h exp 0/022", sram_we, sram_a);
        else pass_cnt++;
        total_cnt++;
        ch_req = 1'b0; #1;
        if (cpu_ack !== 1'b1) $display("FAIL b2b_ack2 got %b exp 1", cpu_ack); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if ({sram_we, sram_a, sram_d} !== {1'b1, 9'h011, 8'h44})
            $display("FAIL b2b_sram2 got %b/%h/%h exp 1/011/44", sram_we, sram_a, sram_d);
        else pass_cnt++;
        total_cnt++;
        cpu_req = 1'b0;
        @(negedge clk);
        if ({ch_q_valid, ch_q, ch_q_num} !== {1'b1, 8'h87, 4'd1})
            $display("FAIL b2b_ch_q got %b/%h/%0d exp 1/87/1", ch_q_valid, ch_q, ch_q_num);
        else pass_cnt++;
        total_cnt++;
    endtask

    task test_oor;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 9'h180; cpu_d = 8'h99; #1;
        if (cpu_ack !== 1'b1) $display("FAIL oor_wr_ack got %b exp 1", cpu_ack); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if ({sram_we, sram_a, sram_d} !== 18'd0)
            $display("FAIL oor_wr_sram got %b/%h/%h exp 0/0/0", sram_we, sram_a, sram_d);
        else pass_cnt++;
        total_cnt++;
        cpu_we = 1'b0; cpu_a = 9'h1FF; #1;
        if (cpu_ack !== 1'b1) $display("FAIL oor_rd_ack got %b exp 1", cpu_ack); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if ({sram_we, sram_a} !== 10'd0) $display("FAIL oor_rd_sram got %b/%h exp 0/0", sram_we, sram_a); else pass_cnt++;
        total_cnt++;
        cpu_req = 1'b0; ch_req = 1'b1; ch_num = 4'd12; ch_ptr = 5'd0; #1;
        if (ch_ack !== 1'b1) $display("FAIL oor_ch_ack got %b exp 1", ch_ack); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        ch_req = 1'b0;
        if (cpu_q_valid !== 1'b0) $display("FAIL oor_wr_noq got %b exp 0", cpu_q_valid); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if ({cpu_q_valid, cpu_q} !== {1'b1, 8'hFF})
            $display("FAIL oor_cpu_q got %b/%h exp 1/ff", cpu_q_valid, cpu_q);
        else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if ({ch_q_valid, ch_q, ch_q_num} !== {1'b1, 8'h00, 4'd12})
            $display("FAIL oor_ch_q got %b/%h/%0d exp 1/00/12", ch_q_valid, ch_q, ch_q_num);
        else pass_cnt++;
        total_cnt++;
    endtask

    task test_reset_mid;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 9'h123; #1;
        if (cpu_ack !== 1'b1) $display("FAIL mid_ack got %b exp 1", cpu_ack); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        cpu_req = 1'b0; reset = 1'b1; #1;
        if ({sram_a, cpu_q} !== 17'd0) $display("FAIL mid_rst_out got %h/%h exp 0/0", sram_a, cpu_q); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        reset = 1'b0;
        if (cpu_q_valid !== 1'b0) $display("FAIL mid_noq1 got %b exp 0", cpu_q_valid); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if (cpu_q_valid !== 1'b0) $display("FAIL mid_noq2 got %b exp 0", cpu_q_valid); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 9'h123;
        ch_req = 1'b1; ch_num = 4'd0; ch_ptr = 5'd5; #1;
        if ({cpu_ack, ch_ack} !== 2'b10) $display("FAIL mid_state got %b%b exp 10", cpu_ack, ch_ack); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        cpu_req = 1'b0; #1;
        if (ch_ack !== 1'b1) $display("FAIL mid_ch_ack got %b exp 1", ch_ack); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        ch_req = 1'b0;
        @(negedge clk);
        if ({cpu_q_valid, cpu_q} !== {1'b1, 8'h5A})
            $display("FAIL mid_cpu_q got %b/%h exp 1/5a", cpu_q_valid, cpu_q);
        else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        if ({ch_q_valid, ch_q} !== {1'b1, 8'hA0})
            $display("FAIL mid_ch_q got %b/%h exp 1/a0", ch_q_valid, ch_q);
        else pass_cnt++;
        total_cnt++;
    endtask

    initial begin
        reset = 1'b1; ram_init = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = 9'd0; cpu_d = 8'd0;
        ch_req = 1'b0; ch_num = 4'd0; ch_ptr = 5'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_cpu_write_read();
        test_ch_fetch();
        test_both();
        test_back_to_back();
        test_oor();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
